// File: rtl/fpu_mac_sched.sv
// Issue scheduler sharing one fused MAC between a scalar FMUL/FMAC port and a 4-step FIPR port.
// Optional statistics counters are enabled with `define FPU_MAC_SCHED_STATS_EN.
module fpu_mac_sched #(
  parameter int unsigned MAC_LAT = 1,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_a,
  input  logic [31:0]      s_b,
  input  logic [31:0]      s_c,
  input  logic             s_sub,
  input  logic [TAG_W-1:0] s_tag,
  output logic             s_rvalid,
  output logic [31:0]      s_rdata,
  output logic [TAG_W-1:0] s_rtag,
  input  logic             v_valid,
  output logic             v_ready,
  input  logic [127:0]     v_a,
  input  logic [127:0]     v_b,
  input  logic [TAG_W-1:0] v_tag,
  output logic             v_rvalid,
  output logic [31:0]      v_rdata,
  output logic [TAG_W-1:0] v_rtag,
  output logic             mac_issue,
  output logic [31:0]      mac_a,
  output logic [31:0]      mac_b,
  output logic [31:0]      mac_c,
  output logic             mac_sub,
  input  logic [31:0]      mac_dest
`ifdef FPU_MAC_SCHED_STATS_EN
  ,
  output logic [31:0]      stat_issue,
  output logic [31:0]      stat_stall
`endif
);

  typedef struct packed {
    logic             valid;
    logic             is_vec;
    logic [TAG_W-1:0] tag;
  } trk_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [1:0]         k_q, k_d;
  logic [127:0]       va_q, va_d, vb_q, vb_d;
  logic [TAG_W-1:0]   vtag_q, vtag_d;
  logic               run_q;
  trk_t               trk_q [MAC_LAT];
  trk_t               push;
  trk_t               head;
  logic               head_vec;
  logic               vec_issue;
  logic [31:0]        vec_a, vec_b, vec_c;
  logic [1:0]         k_sel;
  logic               s_acc;

  // Out-of-reset flag gates the ready outputs so nothing is accepted during reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      va_q    <= '0;
      vb_q    <= '0;
      vtag_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      vtag_q  <= vtag_d;
    end
  end

  // In-flight tracker: the head entry lines up with mac_dest of the op it describes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAC_LAT; i++) trk_q[i] <= '0;
    end else begin
      trk_q[0] <= push;
      for (int unsigned i = 1; i < MAC_LAT; i++) trk_q[i] <= trk_q[i-1];
    end
  end

  assign head     = trk_q[MAC_LAT-1];
  assign head_vec = head.valid & head.is_vec;

  // Vector FSM; WAIT chains the next step directly off mac_dest
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    va_d      = va_q;
    vb_d      = vb_q;
    vtag_d    = vtag_q;
    vec_issue = 1'b0;
    k_sel     = k_q;
    vec_c     = 32'd0;
    v_ready   = 1'b0;
    v_rvalid  = 1'b0;
    v_rdata   = 32'd0;
    v_rtag    = '0;
    case (state_q)
      IDLE: begin
        v_ready = run_q;
        if (v_valid && run_q) begin
          va_d    = v_a;
          vb_d    = v_b;
          vtag_d  = v_tag;
          k_d     = 2'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        vec_issue = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (head_vec) begin
          if (k_q != 2'd3) begin
            vec_issue = 1'b1;
            k_sel     = 2'(k_q + 2'd1);
            vec_c     = mac_dest;
            k_d       = 2'(k_q + 2'd1);
          end else begin
            v_rvalid = 1'b1;
            v_rdata  = mac_dest;
            v_rtag   = vtag_q;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign vec_a = va_q[{k_sel, 5'd0} +: 32];
  assign vec_b = vb_q[{k_sel, 5'd0} +: 32];

  // Slot arbitration: a vector step always owns the MAC
  assign s_ready   = run_q & ~vec_issue;
  assign s_acc     = s_valid & s_ready;
  assign mac_issue = vec_issue | s_acc;
  assign mac_a     = vec_issue ? vec_a : (s_acc ? s_a : 32'd0);
  assign mac_b     = vec_issue ? vec_b : (s_acc ? s_b : 32'd0);
  assign mac_c     = vec_issue ? vec_c : (s_acc ? s_c : 32'd0);
  assign mac_sub   = s_acc & s_sub;

  always_comb begin
    push        = '0;
    push.valid  = mac_issue;
    push.is_vec = vec_issue;
    if (vec_issue)  push.tag = vtag_q;
    else if (s_acc) push.tag = s_tag;
  end

  assign s_rvalid = head.valid & ~head.is_vec;
  assign s_rdata  = s_rvalid ? mac_dest : 32'd0;
  assign s_rtag   = s_rvalid ? head.tag : '0;

`ifdef FPU_MAC_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issue <= 32'd0;
      stat_stall <= 32'd0;
    end else begin
      if (mac_issue)            stat_issue <= 32'(stat_issue + 32'd1);
      if (s_valid && !s_ready)  stat_stall <= 32'(stat_stall + 32'd1);
    end
  end
`endif

endmodule

// File: tb/tb_fpu_mac_sched.sv
// Scoreboard bench for fpu_mac_sched with a behavioural float MAC of latency LAT.
module tb_fpu_mac_sched;
  localparam int unsigned LAT   = 3;
  localparam int unsigned TAG_W = 4;

  logic clk, rst_n;
  logic s_valid, s_ready, s_sub, s_rvalid;
  logic [31:0] s_a, s_b, s_c, s_rdata;
  logic [TAG_W-1:0] s_tag, s_rtag;
  logic v_valid, v_ready, v_rvalid;
  logic [127:0] v_a, v_b;
  logic [TAG_W-1:0] v_tag, v_rtag;
  logic [31:0] v_rdata;
  logic mac_issue, mac_sub;
  logic [31:0] mac_a, mac_b, mac_c, mac_dest;
`ifdef FPU_MAC_SCHED_STATS_EN
  logic [31:0] stat_issue, stat_stall;
`endif

  fpu_mac_sched #(.MAC_LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_c(s_c),
    .s_sub(s_sub), .s_tag(s_tag), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rtag(s_rtag),
    .v_valid(v_valid), .v_ready(v_ready), .v_a(v_a), .v_b(v_b), .v_tag(v_tag),
    .v_rvalid(v_rvalid), .v_rdata(v_rdata), .v_rtag(v_rtag),
    .mac_issue(mac_issue), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_sub(mac_sub), .mac_dest(mac_dest)
`ifdef FPU_MAC_SCHED_STATS_EN
    , .stat_issue(stat_issue), .stat_stall(stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int stall_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Float helpers, exact for the small integer-valued operands used here
  function automatic real f2r(input logic [31:0] x);
    real m;
    int e;
    if (x[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    for (int i = 0; i < 200 && e > 0; i++) begin m = m * 2.0; e--; end
    for (int i = 0; i < 200 && e < 0; i++) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic s;
    int e;
    int man;
    if (r == 0.0) return 32'd0;
    s = (r < 0.0);
    if (s) r = -r;
    e = 0;
    for (int i = 0; i < 200 && r >= 2.0; i++) begin r = r / 2.0; e++; end
    for (int i = 0; i < 200 && r < 1.0; i++) begin r = r * 2.0; e--; end
    man = $rtoi((r - 1.0) * 8388608.0);
    return {s, 8'(e + 127), 23'(man)};
  endfunction

  // Behavioural MAC: result appears LAT cycles after the issue cycle
  logic [31:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = 32'd0;
  always @(posedge clk) begin
    pipe[0] <= mac_issue ? r2f(f2r(mac_a) * f2r(mac_b) + (mac_sub ? -f2r(mac_c) : f2r(mac_c)))
                         : 32'd0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mac_dest = pipe[LAT-1];

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    int               cyc;
  } exp_t;
  exp_t sq[$];
  exp_t vq[$];

  // Monitor: pops expectations whenever the DUT presents a result
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      if (s_rvalid && v_rvalid) check("both_rvalid", 64'(1), 64'(0));
      if (s_rvalid) begin
        if (sq.size() == 0) check("s_unexpected", 64'(1), 64'(0));
        else begin
          e = sq.pop_front();
          check("s_rdata", 64'(s_rdata), 64'(e.data));
          check("s_rtag", 64'(s_rtag), 64'(e.tag));
          check("s_latency", 64'(cyc), 64'(e.cyc));
        end
      end
      if (v_rvalid) begin
        if (vq.size() == 0) check("v_unexpected", 64'(1), 64'(0));
        else begin
          e = vq.pop_front();
          check("v_rdata", 64'(v_rdata), 64'(e.data));
          check("v_rtag", 64'(v_rtag), 64'(e.tag));
          check("v_latency", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic send_s(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic sub, input logic [TAG_W-1:0] tag, input logic [31:0] exp);
    @(posedge clk); #1;
    s_valid = 1'b1; s_a = a; s_b = b; s_c = c; s_sub = sub; s_tag = tag;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (s_ready) begin
        check("s_issue", 64'(mac_issue), 64'(1));
        check("s_mac_a", 64'(mac_a), 64'(a));
        check("s_mac_sub", 64'(mac_sub), 64'(sub));
        sq.push_back('{tag, exp, cyc + LAT});
        return;
      end
      stall_cnt++;
    end
    check("s_accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic s_idle();
    @(posedge clk); #1;
    s_valid = 1'b0; s_a = '0; s_b = '0; s_c = '0; s_sub = 1'b0; s_tag = '0;
  endtask

  task automatic send_v(input logic [127:0] a, input logic [127:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] exp, output int acc);
    acc = -1;
    @(posedge clk); #1;
    v_valid = 1'b1; v_a = a; v_b = b; v_tag = tag;
    for (int n = 0; n < 64 && acc < 0; n++) begin
      @(negedge clk);
      if (v_ready) begin
        acc = cyc;
        vq.push_back('{tag, exp, cyc + 1 + 4 * LAT});
      end
    end
    if (acc < 0) check("v_accept_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    v_valid = 1'b0; v_a = '0; v_b = '0; v_tag = '0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (sq.size() != 0 || vq.size() != 0); n++) @(negedge clk);
    check("drain_sq", 64'(sq.size()), 64'(0));
    check("drain_vq", 64'(vq.size()), 64'(0));
  endtask

  localparam logic [127:0] VA_1234 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [127:0] VB_ONE  = {4{32'h3F800000}};
  localparam logic [127:0] VB_TWO  = {4{32'h40000000}};

  logic [31:0] fa   [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] fexp [8] = '{32'h40400000, 32'h40A00000, 32'h40E00000, 32'h41100000,
                            32'h41300000, 32'h41500000, 32'h41700000, 32'h41880000};

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int tgt;
`ifdef FPU_MAC_SCHED_STATS_EN
    logic [31:0] st0;
`endif
    rst_n = 1'b1;
    s_valid = 1'b0; s_a = '0; s_b = '0; s_c = '0; s_sub = 1'b0; s_tag = '0;
    v_valid = 1'b0; v_a = '0; v_b = '0; v_tag = '0;
    #1 rst_n = 1'b0;
    #20;
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_v_ready", 64'(v_ready), 64'(0));
    check("rst_mac_issue", 64'(mac_issue), 64'(0));
    check("rst_rvalid", 64'({s_rvalid, v_rvalid}), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("idle_s_ready", 64'(s_ready), 64'(1));
    check("idle_v_ready", 64'(v_ready), 64'(1));
    check("idle_mac_ops", 64'({mac_issue, mac_a, mac_b, mac_c, mac_sub}), 64'(0));

    // Single scalar: 2*3+0
    send_s(32'h40000000, 32'h40400000, 32'h0, 1'b0, 4'd5, 32'h40C00000);
    s_idle();
    drain();

    // Back-to-back stream: (i+1)*2+1
    for (int i = 0; i < 8; i++)
      send_s(fa[i], 32'h40000000, 32'h3F800000, 1'b0, 4'(i), fexp[i]);
    s_idle();
    drain();

    // Subtract: 2*3-1
    send_s(32'h40000000, 32'h40400000, 32'h3F800000, 1'b1, 4'd6, 32'h40A00000);
    s_idle();
    drain();

    // FIPR (1,2,3,4).(1,1,1,1)
    send_v(VA_1234, VB_ONE, 4'd9, 32'h41200000, acc);
    drain();

    // FIPR with continuous scalar traffic
    stall_cnt = 0;
`ifdef FPU_MAC_SCHED_STATS_EN
    st0 = stat_stall;
`endif
    fork
      send_v(VA_1234, VB_TWO, 4'd3, 32'h41A00000, acc);
      begin
        for (int i = 0; i < 20; i++)
          send_s(32'h40000000, 32'h40400000, 32'h3F800000, 1'b0, 4'(i), 32'h40E00000);
        s_idle();
      end
    join
    drain();
    check("stall_cycles", 64'(stall_cnt), 64'(4));
`ifdef FPU_MAC_SCHED_STATS_EN
    check("stat_stall", 64'(32'(stat_stall - st0)), 64'(4));
`endif

    // Reset in WAIT with k=2, then a fresh FIPR
    send_v(VA_1234, VB_ONE, 4'd9, 32'h41200000, acc);
    tgt = acc + 2 + 2 * LAT;
    for (int n = 0; n < 100 && cyc < tgt; n++) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ready", 64'({s_ready, v_ready}), 64'(0));
    check("midrst_rvalid", 64'({s_rvalid, v_rvalid}), 64'(0));
    check("midrst_mac", 64'({mac_issue, mac_a, mac_c}), 64'(0));
    sq.delete();
    vq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_v_ready", 64'(v_ready), 64'(1));
    send_v(VA_1234, VB_TWO, 4'd4, 32'h41A00000, acc);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
